// File: rtl/bg_write_arbiter.sv
// bg_write_arbiter
// Round-robin arbiter that shares the background tile-RAM write port among
// NUM_REQ tile writers. It also contains a high-priority screen-clear
// sequencer that zeroes CLEAR_WORDS words starting at address 0.
// RAM-side outputs are registered: a grant in cycle N shows up as a write
// on the RAM port in cycle N+1.

module bg_write_arbiter #(
    parameter int NUM_REQ     = 6,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int CLEAR_WORDS = 1200
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear_start,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         bg_ram_addr,
    output logic [DATA_W-1:0]         bg_ram_data,
    output logic                      bg_wea,
    output logic                      clear_busy,
    output logic                      clear_done
);

    localparam int                PTR_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] CLEAR_LAST   = ADDR_W'(CLEAR_WORDS - 1);
    localparam logic [PTR_W-1:0]  LAST_RESET   = PTR_W'(NUM_REQ - 1);
    localparam bit                CLEAR_SINGLE = (CLEAR_WORDS == 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // Round-robin pointer: index of the most recently granted channel.
    logic [PTR_W-1:0]    r_last;
    // Next clear address to be written.
    logic [ADDR_W-1:0]   r_clr_cnt;
    // The final clear write has been registered; signal completion next cycle.
    logic                r_done_pend;

    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_data;
    logic                r_wea;
    logic                r_clear_busy;
    logic                r_clear_done;

    logic                w_clear_go;
    logic                w_clear_last;
    logic [NUM_REQ-1:0]  w_gnt;
    logic                w_gnt_vld;
    logic [PTR_W-1:0]    w_gnt_idx;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;

    // A clear is accepted only from IDLE, while enabled, and only if the
    // previous clear has fully signalled completion.
    assign w_clear_go   = (r_state == ST_IDLE) && enable && clear_start && !r_clear_busy;
    assign w_clear_last = (r_clr_cnt == CLEAR_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: enter CLEAR on an accepted clear, leave it once the
    // write to the last clear address issues.
    always_comb begin
        // NOTE: combinational outputs get a default first so no path leaves
        // them unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_clear_go && !CLEAR_SINGLE) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (enable && w_clear_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: round-robin grant search starting after r_last, in two
    // passes (channels above r_last, then wrap to channels up to r_last).
    always_comb begin
        w_gnt      = '0;
        w_gnt_vld  = 1'b0;
        w_gnt_idx  = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        if ((r_state == ST_IDLE) && enable && !w_clear_go) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_gnt_vld && req[i] && (i > int'(r_last))) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = PTR_W'(i);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_gnt_vld && req[i] && (i <= int'(r_last))) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = PTR_W'(i);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_gnt_vld && (w_gnt_idx == PTR_W'(i))) begin
                    w_gnt[i]   = 1'b1;
                    w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                    w_sel_data = req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // RAM port registers, clear sequencer and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ram_addr   <= '0;
            r_ram_data   <= '0;
            r_wea        <= 1'b0;
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b0;
            r_clr_cnt    <= '0;
            r_done_pend  <= 1'b0;
            r_last       <= LAST_RESET;
        end else begin
            r_clear_done <= r_done_pend;
            r_done_pend  <= 1'b0;
            r_wea        <= 1'b0;
            if (r_done_pend) begin
                r_clear_busy <= 1'b0;
            end

            if (r_state == ST_CLEAR) begin
                // Enable low pauses the clear: counter holds, no write.
                if (enable) begin
                    r_ram_addr <= r_clr_cnt;
                    r_ram_data <= '0;
                    r_wea      <= 1'b1;
                    r_clr_cnt  <= r_clr_cnt + ADDR_W'(1);
                    if (w_clear_last) begin
                        r_done_pend <= 1'b1;
                    end
                end
            end else if (w_clear_go) begin
                // Address 0 is written straight away so the first clear write
                // lands on the port the cycle after clear_start; the counter
                // therefore continues from 1.
                r_ram_addr   <= '0;
                r_ram_data   <= '0;
                r_wea        <= 1'b1;
                r_clr_cnt    <= ADDR_W'(1);
                r_clear_busy <= 1'b1;
                if (CLEAR_SINGLE) begin
                    r_done_pend <= 1'b1;
                end
            end else if (w_gnt_vld) begin
                r_ram_addr <= w_sel_addr;
                r_ram_data <= w_sel_data;
                r_wea      <= 1'b1;
                r_last     <= w_gnt_idx;
            end
        end
    end

    assign gnt         = w_gnt;
    assign bg_ram_addr = r_ram_addr;
    assign bg_ram_data = r_ram_data;
    assign bg_wea      = r_wea;
    assign clear_busy  = r_clear_busy;
    assign clear_done  = r_clear_done;

endmodule

// File: tb/tb_bg_write_arbiter.sv
// Self-checking bench for bg_write_arbiter. A behavioural model tracks the
// round-robin pointer and clear progress with plain integers, and predicts
// the grant and the registered RAM-port outputs every cycle.

module tb_bg_write_arbiter;

    localparam int NUM_REQ     = 6;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 32;
    localparam int CLEAR_WORDS = 1200;
    localparam int PTR_W       = 3;
    localparam int VW          = 1 + ADDR_W + DATA_W + 2;

    logic                      clk;
    logic                      reset;
    logic                      enable;
    logic                      clear_start;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         bg_ram_addr;
    logic [DATA_W-1:0]         bg_ram_data;
    logic                      bg_wea;
    logic                      clear_busy;
    logic                      clear_done;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int                m_last;
    bit                m_busy;
    bit                m_clearing;
    bit                m_pend;
    int                m_cnt;
    bit                m_wea;
    bit                m_done;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;

    bg_write_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_WORDS(CLEAR_WORDS)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear_start(clear_start),
        .req(req), .req_addr(req_addr), .req_data(req_data), .gnt(gnt),
        .bg_ram_addr(bg_ram_addr), .bg_ram_data(bg_ram_data), .bg_wea(bg_wea),
        .clear_busy(clear_busy), .clear_done(clear_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_last     = NUM_REQ - 1;
        m_busy     = 0;
        m_clearing = 0;
        m_pend     = 0;
        m_cnt      = 0;
        m_wea      = 0;
        m_done     = 0;
        m_addr     = '0;
        m_data     = '0;
    endtask

    // Expected grant: first requester after m_last, wrapping modulo NUM_REQ.
    function automatic logic [NUM_REQ-1:0] model_gnt();
        logic [NUM_REQ-1:0] g;
        int k;
        g = '0;
        if (!enable || m_clearing || (clear_start && !m_busy)) return g;
        for (int j = 1; j <= NUM_REQ; j++) begin
            k = (m_last + j) % NUM_REQ;
            if (req[PTR_W'(k)]) begin
                g[PTR_W'(k)] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_edge();
        logic [NUM_REQ-1:0] g;
        bit busy_old;
        g        = model_gnt();
        busy_old = m_busy;
        m_done   = m_pend;
        if (m_pend) m_busy = 0;
        m_pend = 0;
        if (m_clearing) begin
            if (enable) begin
                m_wea  = 1;
                m_addr = ADDR_W'(m_cnt);
                m_data = '0;
                m_cnt  = m_cnt + 1;
                if (m_cnt == CLEAR_WORDS) begin
                    m_clearing = 0;
                    m_pend     = 1;
                end
            end else begin
                m_wea = 0;
            end
        end else if (enable && clear_start && !busy_old) begin
            m_wea      = 1;
            m_addr     = '0;
            m_data     = '0;
            m_cnt      = 1;
            m_busy     = 1;
            m_clearing = 1;
        end else if (g != '0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (g[k]) begin
                    m_addr = req_addr[k*ADDR_W +: ADDR_W];
                    m_data = req_data[k*DATA_W +: DATA_W];
                    m_last = k;
                end
            end
            m_wea = 1;
        end else begin
            m_wea = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [VW-1:0] dut_vec();
        return {bg_wea, bg_ram_addr, bg_ram_data, clear_busy, clear_done};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_wea, m_addr, m_data, m_busy, m_done};
    endfunction

    task automatic rand_payload();
        req_addr = {$urandom, $urandom, $urandom};
        req_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec() !== '0 || gnt !== '0)
            $display("FAIL reset_state: got out=%h gnt=%b required out=0 gnt=0", dut_vec(), gnt);
        else n_pass++;
        reset = 1'b1;
        enable = 1'b1;
        model_reset();
        tick();
        n_checks++;
        if (dut_vec() !== exp_vec())
            $display("FAIL reset_release: got %h required %h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_single();
        req = 6'b000001;
        req_addr[15:0] = 16'h0045;
        req_data[31:0] = 32'h0000_0186;
        #1;
        n_checks++;
        if (gnt !== 6'b000001) $display("FAIL single_gnt: got %b required 000001", gnt);
        else n_pass++;
        tick();
        req = '0;
        n_checks++;
        if (bg_wea !== 1'b1 || bg_ram_addr !== 16'h0045 || bg_ram_data !== 32'h186)
            $display("FAIL single_write: got wea=%b addr=%h data=%h required 1/0045/00000186",
                     bg_wea, bg_ram_addr, bg_ram_data);
        else n_pass++;
        #1;
        tick();
        n_checks++;
        if (bg_wea !== 1'b0 || bg_ram_addr !== 16'h0045)
            $display("FAIL single_idle: got wea=%b addr=%h required 0/0045", bg_wea, bg_ram_addr);
        else n_pass++;
    endtask

    task automatic test_all_req();
        int cnt[NUM_REQ];
        foreach (cnt[k]) cnt[k] = 0;
        req = '1;
        for (int c = 0; c < 12; c++) begin
            rand_payload();
            #1;
            n_checks++;
            if (gnt !== model_gnt()) $display("FAIL all_gnt: cycle %0d got %b required %b", c, gnt, model_gnt());
            else n_pass++;
            for (int k = 0; k < NUM_REQ; k++) if (gnt[k]) cnt[k]++;
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL all_out: cycle %0d got %h required %h", c, dut_vec(), exp_vec());
            else n_pass++;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            n_checks++;
            if (cnt[k] != 2) $display("FAIL all_count: channel %0d granted %0d times required 2", k, cnt[k]);
            else n_pass++;
        end
        req = '0;
        tick();
    endtask

    task automatic test_pair();
        int exp_ord[4] = '{5, 2, 5, 2};
        logic [NUM_REQ-1:0] e;
        req = 6'b000100;
        rand_payload();
        #1;
        tick();
        req = 6'b100100;
        for (int i = 0; i < 4; i++) begin
            rand_payload();
            #1;
            e = '0;
            e[PTR_W'(exp_ord[i])] = 1'b1;
            n_checks++;
            if (gnt !== e) $display("FAIL pair_gnt: step %0d got %b required %b", i, gnt, e);
            else n_pass++;
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL pair_out: step %0d got %h required %h", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        req = '0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            enable = ($urandom_range(0, 9) != 0);
            req    = NUM_REQ'($urandom);
            rand_payload();
            #1;
            n_checks++;
            if (gnt !== model_gnt()) $display("FAIL rand_gnt: cycle %0d got %b required %b", c, gnt, model_gnt());
            else n_pass++;
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL rand_out: cycle %0d got %h required %h", c, dut_vec(), exp_vec());
            else n_pass++;
        end
        enable = 1'b1;
        req = '0;
        tick();
    endtask

    task automatic test_clear();
        int  exp_next  = 0;
        int  done_cnt  = 0;
        int  pause_left = 0;
        bit  paused    = 0;
        bit  restarted = 0;
        int  post      = 0;
        enable      = 1'b1;
        req         = 6'b000011;
        rand_payload();
        clear_start = 1'b1;
        #1;
        n_checks++;
        if (gnt !== '0) $display("FAIL clear_start_gnt: got %b required 000000", gnt);
        else n_pass++;
        for (int cyc = 0; cyc < 3000 && post < 4; cyc++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL clear_out: cycle %0d got %h required %h", cyc, dut_vec(), exp_vec());
            else n_pass++;
            if (bg_wea && clear_busy) begin
                n_checks++;
                if (bg_ram_addr !== ADDR_W'(exp_next) || bg_ram_data !== '0)
                    $display("FAIL clear_seq: got addr=%0d data=%h required addr=%0d data=0",
                             bg_ram_addr, bg_ram_data, exp_next);
                else n_pass++;
                exp_next++;
            end
            if (clear_done) done_cnt++;
            if (done_cnt > 0) post++;
            // stimulus for the next cycle
            if (exp_next == 300 && !paused) begin
                paused = 1;
                pause_left = 5;
            end
            enable = (pause_left == 0);
            if (pause_left > 0) pause_left--;
            if (exp_next == 600 && !restarted) begin
                clear_start = 1'b1;
                restarted = 1;
            end else begin
                clear_start = 1'b0;
            end
            #1;
            n_checks++;
            if (gnt !== model_gnt()) $display("FAIL clear_gnt: cycle %0d got %b required %b", cyc, gnt, model_gnt());
            else n_pass++;
        end
        n_checks++;
        if (exp_next != CLEAR_WORDS) $display("FAIL clear_words: got %0d writes required %0d", exp_next, CLEAR_WORDS);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1) $display("FAIL clear_done_count: got %0d pulses required 1", done_cnt);
        else n_pass++;
        clear_start = 1'b0;
        enable = 1'b1;
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid_clear();
        enable = 1'b1;
        clear_start = 1'b1;
        #1;
        tick();
        clear_start = 1'b0;
        for (int cyc = 0; cyc < 2000 && m_cnt < 700; cyc++) tick();
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL midclr_pre: got %h required %h", dut_vec(), exp_vec());
        else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bg_wea !== 1'b0 || clear_busy !== 1'b0 || dut_vec() !== '0)
            $display("FAIL midclr_async: got %h required 0", dut_vec());
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        req = '1;
        rand_payload();
        #1;
        n_checks++;
        if (gnt !== 6'b000001) $display("FAIL midclr_first_gnt: got %b required 000001", gnt);
        else n_pass++;
        tick();
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL midclr_first_out: got %h required %h", dut_vec(), exp_vec());
        else n_pass++;
        req = '0;
    endtask

    initial begin
        reset       = 1'b0;
        enable      = 1'b0;
        clear_start = 1'b0;
        req         = '0;
        req_addr    = '0;
        req_data    = '0;
        model_reset();
        test_reset();
        test_single();
        test_all_req();
        test_pair();
        test_random();
        test_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
